// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_LINK_ADDR = 31;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, link write, issue/pending and clear control.
interface regfile_mp_if #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
);
    import regfile_pkg::*;

    logic [ADDR_W-1:0] rd0_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] rd0_data;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] dbg_data;
    logic              rd0_pend;
    logic              rd1_pend;

    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;

    logic              lnk_en;
    logic [DATA_W-1:0] lnk_data;

    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;

    logic              clr_req;
    logic              ready;

    modport master (
        output rd0_addr, rd1_addr, dbg_addr,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output lnk_en, lnk_data,
        output pend_set, pend_addr,
        output clr_req,
        input  rd0_data, rd1_data, dbg_data,
        input  rd0_pend, rd1_pend,
        input  ready
    );

    modport slave (
        input  rd0_addr, rd1_addr, dbg_addr,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  lnk_en, lnk_data,
        input  pend_set, pend_addr,
        input  clr_req,
        output rd0_data, rd1_data, dbg_data,
        output rd0_pend, rd1_pend,
        output ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue, cleared by writes, read on two ports.
module regfile_scoreboard #(
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_all,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr0_en,
    input  logic [ADDR_W-1:0] clr0_addr,
    input  logic              clr1_en,
    input  logic [ADDR_W-1:0] clr1_addr,
    input  logic              clr2_en,
    input  logic [ADDR_W-1:0] clr2_addr,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd0_pend,
    output logic              rd1_pend
);
    import regfile_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;

    // Written registers drop their bit; an issue applied last so it wins on a collision.
    always_comb begin
        pend_nxt = pend;
        if (clr0_en) pend_nxt[clr0_addr] = 1'b0;
        if (clr1_en) pend_nxt[clr1_addr] = 1'b0;
        if (clr2_en) pend_nxt[clr2_addr] = 1'b0;
        if (set_en)  pend_nxt[set_addr]  = 1'b1;
    end

    // Pending bits are wiped by reset and by a clear request, otherwise follow the next-state vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else if (clr_all) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign rd0_pend = pend[rd0_addr];
    assign rd1_pend = pend[rd1_addr];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending scoreboard, link-register write and a hardware clear sweep.
// Optional macro REGFILE_MP_BYPASS_EN forwards same-cycle write data and pending status to rd0/rd1.
module regfile_mp #(
    parameter int DATA_W    = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W    = regfile_pkg::DEF_ADDR_W,
    parameter int LINK_ADDR = regfile_pkg::DEF_LINK_ADDR
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    import regfile_pkg::*;

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              ready_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr0_go;
    logic              wr1_go;
    logic              lnk_go;
    logic              pend_go;
    logic              clr_all;
    logic              sb_pend0;
    logic              sb_pend1;
    logic [DATA_W-1:0] rd0_val;
    logic [DATA_W-1:0] rd1_val;
    logic              rd0_pend_val;
    logic              rd1_pend_val;

    assign wr0_go  = ready_q & bus.wr0_en;
    assign wr1_go  = ready_q & bus.wr1_en;
    assign lnk_go  = ready_q & bus.lnk_en;
    assign pend_go = ready_q & bus.pend_set;
    assign clr_all = ready_q & bus.clr_req;

    // Sweep controller: walk every entry once after reset or a clear request, then hold READY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zero one entry per cycle while sweeping, else apply writes with later statements winning.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (lnk_go) mem[LINK_IDX]     <= bus.lnk_data;
            if (wr0_go) mem[bus.wr0_addr] <= bus.wr0_data;
            if (wr1_go) mem[bus.wr1_addr] <= bus.wr1_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .clr_all   (clr_all),
        .set_en    (pend_go),
        .set_addr  (bus.pend_addr),
        .clr0_en   (wr0_go),
        .clr0_addr (bus.wr0_addr),
        .clr1_en   (wr1_go),
        .clr1_addr (bus.wr1_addr),
        .clr2_en   (lnk_go),
        .clr2_addr (LINK_IDX),
        .rd0_addr  (bus.rd0_addr),
        .rd1_addr  (bus.rd1_addr),
        .rd0_pend  (sb_pend0),
        .rd1_pend  (sb_pend1)
    );

    // Operand port 0 read path, optionally forwarding an in-flight write, blanked while not ready.
    always_comb begin
        rd0_val      = mem[bus.rd0_addr];
        rd0_pend_val = sb_pend0;
`ifdef REGFILE_MP_BYPASS_EN
        if (wr1_go && (bus.wr1_addr == bus.rd0_addr)) begin
            rd0_val      = bus.wr1_data;
            rd0_pend_val = 1'b0;
        end else if (wr0_go && (bus.wr0_addr == bus.rd0_addr)) begin
            rd0_val      = bus.wr0_data;
            rd0_pend_val = 1'b0;
        end else if (lnk_go && (LINK_IDX == bus.rd0_addr)) begin
            rd0_val      = bus.lnk_data;
            rd0_pend_val = 1'b0;
        end
`endif
        if (!ready_q) begin
            rd0_val      = '0;
            rd0_pend_val = 1'b0;
        end
    end

    // Operand port 1 read path, same forwarding and blanking rules as port 0.
    always_comb begin
        rd1_val      = mem[bus.rd1_addr];
        rd1_pend_val = sb_pend1;
`ifdef REGFILE_MP_BYPASS_EN
        if (wr1_go && (bus.wr1_addr == bus.rd1_addr)) begin
            rd1_val      = bus.wr1_data;
            rd1_pend_val = 1'b0;
        end else if (wr0_go && (bus.wr0_addr == bus.rd1_addr)) begin
            rd1_val      = bus.wr0_data;
            rd1_pend_val = 1'b0;
        end else if (lnk_go && (LINK_IDX == bus.rd1_addr)) begin
            rd1_val      = bus.lnk_data;
            rd1_pend_val = 1'b0;
        end
`endif
        if (!ready_q) begin
            rd1_val      = '0;
            rd1_pend_val = 1'b0;
        end
    end

    assign bus.rd0_data = rd0_val;
    assign bus.rd1_data = rd1_val;
    assign bus.rd0_pend = rd0_pend_val;
    assign bus.rd1_pend = rd1_pend_val;
    assign bus.dbg_data = ready_q ? mem[bus.dbg_addr] : '0;
    assign bus.ready    = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; expectations follow the bypass macro when it is defined.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_compared   = 0;
    int n_mismatched = 0;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    regfile_mp #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LINK_ADDR (31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bus.wr0_en    = 1'b0;
        bus.wr0_addr  = '0;
        bus.wr0_data  = '0;
        bus.wr1_en    = 1'b0;
        bus.wr1_addr  = '0;
        bus.wr1_data  = '0;
        bus.lnk_en    = 1'b0;
        bus.lnk_data  = '0;
        bus.pend_set  = 1'b0;
        bus.pend_addr = '0;
        bus.clr_req   = 1'b0;
    endtask

    task automatic clockTick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                                 input logic l, input logic [DATA_W-1:0] ld,
                                 input logic ps, input logic [ADDR_W-1:0] pa);
        bus.wr0_en    = w0;
        bus.wr0_addr  = a0;
        bus.wr0_data  = d0;
        bus.wr1_en    = w1;
        bus.wr1_addr  = a1;
        bus.wr1_data  = d1;
        bus.lnk_en    = l;
        bus.lnk_data  = ld;
        bus.pend_set  = ps;
        bus.pend_addr = pa;
        clockTick();
        idleInputs();
    endtask

    task automatic checkSweep(input string tag);
        for (int i = 1; i <= 64; i++) begin
            clockTick();
            checkOutput(tag, 32'(bus.ready), 32'(i == 64));
        end
    endtask

    initial begin
        idleInputs();
        bus.rd0_addr = '0;
        bus.rd1_addr = '0;
        bus.dbg_addr = '0;

        // Reset held low: not ready, reads blanked.
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", 32'(bus.ready), 32'd0);
        checkOutput("reset_rd0_data", bus.rd0_data, 32'd0);
        checkOutput("reset_rd0_pend", 32'(bus.rd0_pend), 32'd0);

        // Release and count the 64-cycle sweep.
        @(negedge clk);
        rst = 1'b1;
        checkSweep("sweep_ready");
        bus.rd0_addr = 6'd5;
        bus.dbg_addr = 6'd63;
        #1;
        checkOutput("post_sweep_rd0_a5", bus.rd0_data, 32'd0);
        checkOutput("post_sweep_dbg_a63", bus.dbg_data, 32'd0);

        // Same-address write priority: wr1 beats wr0.
        applyStimulus(1'b1, 6'd3, 32'hAAAA0000, 1'b1, 6'd3, 32'h5555, 1'b0, 32'd0, 1'b0, 6'd0);
        bus.rd0_addr = 6'd3;
        #1;
        checkOutput("prio_wr1_over_wr0", bus.rd0_data, 32'h5555);

        // Distinct targets all land on one edge.
        applyStimulus(1'b1, 6'd10, 32'h11, 1'b1, 6'd11, 32'h22, 1'b1, 32'h33, 1'b0, 6'd0);
        bus.rd0_addr = 6'd10;
        bus.rd1_addr = 6'd11;
        bus.dbg_addr = 6'd31;
        #1;
        checkOutput("multi_wr0", bus.rd0_data, 32'h11);
        checkOutput("multi_wr1", bus.rd1_data, 32'h22);
        checkOutput("multi_lnk", bus.dbg_data, 32'h33);

        // Link register writes and priority against it.
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 32'h100, 1'b0, 6'd0);
        bus.rd1_addr = 6'd31;
        #1;
        checkOutput("lnk_write", bus.rd1_data, 32'h100);
        applyStimulus(1'b1, 6'd31, 32'd7, 1'b0, 6'd0, 32'd0, 1'b1, 32'h200, 1'b0, 6'd0);
        #1;
        checkOutput("wr0_over_lnk", bus.rd1_data, 32'd7);
        applyStimulus(1'b1, 6'd31, 32'd8, 1'b1, 6'd31, 32'd9, 1'b1, 32'h300, 1'b0, 6'd0);
        #1;
        checkOutput("wr1_over_all", bus.rd1_data, 32'd9);

        // Scoreboard set, clear by write, set wins over write.
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1, 6'd9);
        bus.rd0_addr = 6'd9;
        bus.rd1_addr = 6'd9;
        #1;
        checkOutput("pend_set_rd0", 32'(bus.rd0_pend), 32'd1);
        checkOutput("pend_set_rd1", 32'(bus.rd1_pend), 32'd1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd9, 32'h99, 1'b0, 32'd0, 1'b0, 6'd0);
        #1;
        checkOutput("pend_clr_by_wr1", 32'(bus.rd0_pend), 32'd0);
        applyStimulus(1'b1, 6'd9, 32'h98, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1, 6'd9);
        #1;
        checkOutput("pend_set_wins", 32'(bus.rd0_pend), 32'd1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1, 6'd31);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 32'h400, 1'b0, 6'd0);
        bus.rd1_addr = 6'd31;
        #1;
        checkOutput("pend_clr_by_lnk", 32'(bus.rd1_pend), 32'd0);

        // Same-cycle read of an address being written.
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1, 6'd2);
        bus.wr0_en   = 1'b1;
        bus.wr0_addr = 6'd2;
        bus.wr0_data = 32'hDEAD;
        bus.rd0_addr = 6'd2;
        bus.dbg_addr = 6'd2;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        checkOutput("bypass_rd0_data", bus.rd0_data, 32'hDEAD);
        checkOutput("bypass_rd0_pend", 32'(bus.rd0_pend), 32'd0);
`else
        checkOutput("nobypass_rd0_data", bus.rd0_data, 32'd0);
        checkOutput("nobypass_rd0_pend", 32'(bus.rd0_pend), 32'd1);
`endif
        checkOutput("dbg_not_bypassed", bus.dbg_data, 32'd0);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("after_write_a2", bus.rd0_data, 32'hDEAD);
        checkOutput("after_write_pend_a2", 32'(bus.rd0_pend), 32'd0);

        // Clear request: sweep ignores writes, issues and repeated requests.
        applyStimulus(1'b1, 6'd4, 32'h1234, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        bus.rd0_addr = 6'd4;
        #1;
        checkOutput("pre_clear_a4", bus.rd0_data, 32'h1234);
        bus.clr_req = 1'b1;
        clockTick();
        bus.wr0_en    = 1'b1;
        bus.wr0_addr  = 6'd4;
        bus.wr0_data  = 32'hFFFF;
        bus.pend_set  = 1'b1;
        bus.pend_addr = 6'd20;
        #1;
        checkOutput("clear_ready_low", 32'(bus.ready), 32'd0);
        checkOutput("clear_rd0_blank", bus.rd0_data, 32'd0);
        checkSweep("clear_sweep_ready");
        idleInputs();
        bus.rd1_addr = 6'd20;
        bus.dbg_addr = 6'd10;
        #1;
        checkOutput("clear_a4_zero", bus.rd0_data, 32'd0);
        checkOutput("clear_pend20_ignored", 32'(bus.rd1_pend), 32'd0);
        checkOutput("clear_dbg_a10_zero", bus.dbg_data, 32'd0);
        bus.rd0_addr = 6'd9;
        #1;
        checkOutput("clear_pend9_wiped", 32'(bus.rd0_pend), 32'd0);

        // Asynchronous reset from READY wipes pending bits.
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1, 6'd12);
        bus.rd0_addr = 6'd12;
        #1;
        checkOutput("pend12_set", 32'(bus.rd0_pend), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async_reset_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        checkSweep("reset_sweep_ready");
        #1;
        checkOutput("reset_pend12_wiped", 32'(bus.rd0_pend), 32'd0);

        // Reset during a sweep restarts it from entry 0.
        applyStimulus(1'b1, 6'd15, 32'hBEEF, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        bus.clr_req = 1'b1;
        clockTick();
        bus.clr_req = 1'b0;
        repeat (10) clockTick();
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkSweep("restart_sweep_ready");
        bus.rd0_addr = 6'd15;
        #1;
        checkOutput("restart_a15_zero", bus.rd0_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
